// File: rtl/stage_ex_if.sv
// ID/EX-side bundle for the execute stage: decoded instruction in, MEM-stage fields out.
// Latency: none, wires only.
// Backpressure: stall travels master-ward; halt/flush travel slave-ward.
interface stage_ex_if #(
    parameter int reg_addr_width = 5,
    parameter int mem_addr_width = 32,
    parameter int word_width     = 32
);
    logic                      halt;
    logic                      flush;
    logic [mem_addr_width-1:0] pc_in;
    logic [word_width-1:0]     rs1_val_in;
    logic [word_width-1:0]     rs2_val_in;
    logic [word_width-1:0]     imm_ext_in;
    logic [reg_addr_width-1:0] rs1_addr_in;
    logic [reg_addr_width-1:0] rs2_addr_in;
    logic [reg_addr_width-1:0] rd_addr_in;
    logic [3:0]                alu_op_in;
    logic                      alu_src_in;
    logic                      md_en_in;
    logic [2:0]                md_op_in;
    logic [2:0]                bch_typ_in;
    logic                      jmp_ctl_in;
    logic                      jalr_in;
    logic                      bch_ctl_in;
    logic                      mem_ctl_in;
    logic                      rd_wen_in;
    logic [1:0]                wb_ctl_in;
    logic [2:0]                byt_typ_in;
    logic                      mem_fwd_en;
    logic                      wb_fwd_en;
    logic [reg_addr_width-1:0] mem_rd;
    logic [reg_addr_width-1:0] wb_rd;
    logic [word_width-1:0]     mem_fwd_val;
    logic [word_width-1:0]     wb_fwd_val;

    logic [mem_addr_width-1:0] tgt_addr_out;
    logic [word_width-1:0]     rs2_val_out;
    logic [word_width-1:0]     rslt_out;
    logic [word_width-1:0]     imm_ext_out;
    logic                      jmp_ctl_out;
    logic                      bch_ctl_out;
    logic                      mem_ctl_out;
    logic                      rd_wen_out;
    logic [1:0]                wb_ctl_out;
    logic [2:0]                byt_typ_out;
    logic [reg_addr_width-1:0] rd_addr_out;
    logic                      stall;

    // Execute stage side
    modport slave (
        input  halt, flush, pc_in, rs1_val_in, rs2_val_in, imm_ext_in,
               rs1_addr_in, rs2_addr_in, rd_addr_in, alu_op_in, alu_src_in,
               md_en_in, md_op_in, bch_typ_in, jmp_ctl_in, jalr_in, bch_ctl_in,
               mem_ctl_in, rd_wen_in, wb_ctl_in, byt_typ_in,
               mem_fwd_en, wb_fwd_en, mem_rd, wb_rd, mem_fwd_val, wb_fwd_val,
        output tgt_addr_out, rs2_val_out, rslt_out, imm_ext_out,
               jmp_ctl_out, bch_ctl_out, mem_ctl_out, rd_wen_out,
               wb_ctl_out, byt_typ_out, rd_addr_out, stall
    );

    // Decode / hazard-unit side
    modport master (
        output halt, flush, pc_in, rs1_val_in, rs2_val_in, imm_ext_in,
               rs1_addr_in, rs2_addr_in, rd_addr_in, alu_op_in, alu_src_in,
               md_en_in, md_op_in, bch_typ_in, jmp_ctl_in, jalr_in, bch_ctl_in,
               mem_ctl_in, rd_wen_in, wb_ctl_in, byt_typ_in,
               mem_fwd_en, wb_fwd_en, mem_rd, wb_rd, mem_fwd_val, wb_fwd_val,
        input  tgt_addr_out, rs2_val_out, rslt_out, imm_ext_out,
               jmp_ctl_out, bch_ctl_out, mem_ctl_out, rd_wen_out,
               wb_ctl_out, byt_typ_out, rd_addr_out, stall
    );
endinterface

// File: rtl/stage_ex.sv
// RV32IM execute stage: ID/EX register, MEM/WB forwarding, ALU/branch/jump, iterative mul/div.
// Latency: 0 cycles after the ID/EX register; mul/div results appear 33 cycles after load.
// Backpressure: stall holds IF/ID while a mul/div is pending; control outputs are bubbled meanwhile.
module stage_ex #(
    parameter int reg_addr_width = 5,
    parameter int mem_addr_width = 32,
    parameter int word_width     = 32
) (
    input logic        clk,
    input logic        rst,
    stage_ex_if.slave  bus
);
    localparam int W  = word_width;
    localparam int M  = mem_addr_width;
    localparam int SW = $clog2(word_width);

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                           ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                           ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_AUIPC = 4'd10;

    localparam logic [W-1:0] JALR_MASK = {{(W-1){1'b1}}, 1'b0};

    typedef struct packed {
        logic [M-1:0]              pc;
        logic [W-1:0]              rs1_val;
        logic [W-1:0]              rs2_val;
        logic [W-1:0]              imm;
        logic [reg_addr_width-1:0] rs1_addr;
        logic [reg_addr_width-1:0] rs2_addr;
        logic [reg_addr_width-1:0] rd_addr;
        logic [3:0]                alu_op;
        logic                      alu_src;
        logic                      md_en;
        logic [2:0]                md_op;
        logic [2:0]                bch_typ;
        logic                      jmp;
        logic                      jalr;
        logic                      bch;
        logic                      mem;
        logic                      rd_wen;
        logic [1:0]                wb_ctl;
        logic [2:0]                byt_typ;
    } idex_t;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} md_state_e;

    idex_t     idex_q, idex_d;
    md_state_e state_q, state_d;
    logic      stall;
    logic      md_start;

    logic [W-1:0]   rs1_fwd, rs2_fwd;
    logic [W-1:0]   op_b, alu_res, pc_w, jalr_sum, md_res;
    logic [SW-1:0]  shamt;
    logic           bch_take;

    // mul/div working registers
    logic [SW-1:0]  cnt_q;
    logic [2*W-1:0] acc_q, mcand_q;
    logic [W-1:0]   mplier_q, quo_q, rem_q, dvsr_q;
    logic           a_neg_q, b_neg_q, dz_q;

    // start-of-op operand conditioning
    logic           a_sgn, b_sgn;
    logic [W-1:0]   a_mag, b_mag;

    // restoring-divide step
    logic [W-1:0]   rem_shl;
    logic           rem_ge;

    // result fixups
    logic [2*W-1:0] prod_s;
    logic [W-1:0]   quo_s, rem_s;

    // Collect the incoming decoded instruction into one word
    always_comb begin
        idex_d          = '0;
        idex_d.pc       = bus.pc_in;
        idex_d.rs1_val  = bus.rs1_val_in;
        idex_d.rs2_val  = bus.rs2_val_in;
        idex_d.imm      = bus.imm_ext_in;
        idex_d.rs1_addr = bus.rs1_addr_in;
        idex_d.rs2_addr = bus.rs2_addr_in;
        idex_d.rd_addr  = bus.rd_addr_in;
        idex_d.alu_op   = bus.alu_op_in;
        idex_d.alu_src  = bus.alu_src_in;
        idex_d.md_en    = bus.md_en_in;
        idex_d.md_op    = bus.md_op_in;
        idex_d.bch_typ  = bus.bch_typ_in;
        idex_d.jmp      = bus.jmp_ctl_in;
        idex_d.jalr     = bus.jalr_in;
        idex_d.bch      = bus.bch_ctl_in;
        idex_d.mem      = bus.mem_ctl_in;
        idex_d.rd_wen   = bus.rd_wen_in;
        idex_d.wb_ctl   = bus.wb_ctl_in;
        idex_d.byt_typ  = bus.byt_typ_in;
    end

    // ID/EX register: flush clears it to a bubble, stall or halt hold it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idex_q <= '0;
        end else if (!bus.halt) begin
            if (bus.flush) begin
                idex_q <= '0;
            end else if (!stall) begin
                idex_q <= idex_d;
            end
        end
    end

    // Operand forwarding, MEM before WB, never for x0
    always_comb begin
        rs1_fwd = idex_q.rs1_val;
        rs2_fwd = idex_q.rs2_val;
        if (idex_q.rs1_addr != '0) begin
            if (bus.mem_fwd_en && (bus.mem_rd == idex_q.rs1_addr)) begin
                rs1_fwd = bus.mem_fwd_val;
            end else if (bus.wb_fwd_en && (bus.wb_rd == idex_q.rs1_addr)) begin
                rs1_fwd = bus.wb_fwd_val;
            end
        end
        if (idex_q.rs2_addr != '0) begin
            if (bus.mem_fwd_en && (bus.mem_rd == idex_q.rs2_addr)) begin
                rs2_fwd = bus.mem_fwd_val;
            end else if (bus.wb_fwd_en && (bus.wb_rd == idex_q.rs2_addr)) begin
                rs2_fwd = bus.wb_fwd_val;
            end
        end
    end

    // ALU and branch comparator
    always_comb begin
        pc_w  = W'(idex_q.pc);
        op_b  = idex_q.alu_src ? idex_q.imm : rs2_fwd;
        shamt = op_b[SW-1:0];
        case (idex_q.alu_op)
            ALU_ADD:   alu_res = rs1_fwd + op_b;
            ALU_SUB:   alu_res = rs1_fwd - op_b;
            ALU_SLL:   alu_res = rs1_fwd << shamt;
            ALU_SLT:   alu_res = {{(W-1){1'b0}}, $signed(rs1_fwd) < $signed(op_b)};
            ALU_SLTU:  alu_res = {{(W-1){1'b0}}, rs1_fwd < op_b};
            ALU_XOR:   alu_res = rs1_fwd ^ op_b;
            ALU_SRL:   alu_res = rs1_fwd >> shamt;
            ALU_SRA:   alu_res = $unsigned($signed(rs1_fwd) >>> shamt);
            ALU_OR:    alu_res = rs1_fwd | op_b;
            ALU_AND:   alu_res = rs1_fwd & op_b;
            ALU_AUIPC: alu_res = pc_w + idex_q.imm;
            default:   alu_res = '0;
        endcase
        case (idex_q.bch_typ)
            3'd0:    bch_take = (rs1_fwd == rs2_fwd);
            3'd1:    bch_take = (rs1_fwd != rs2_fwd);
            3'd4:    bch_take = ($signed(rs1_fwd) <  $signed(rs2_fwd));
            3'd5:    bch_take = ($signed(rs1_fwd) >= $signed(rs2_fwd));
            3'd6:    bch_take = (rs1_fwd <  rs2_fwd);
            3'd7:    bch_take = (rs1_fwd >= rs2_fwd);
            default: bch_take = 1'b0;
        endcase
        jalr_sum = rs1_fwd + idex_q.imm;
    end

    // Mul/div FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else if (!bus.halt) begin
            state_q <= state_d;
        end
    end

    // Mul/div FSM next state; flush aborts from any state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (idex_q.md_en) state_d = S_BUSY;
            S_BUSY:  if (cnt_q == '0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (bus.flush) begin
            state_d = S_IDLE;
        end
    end

    // Mul/div FSM outputs
    always_comb begin
        stall    = idex_q.md_en && (state_q != S_DONE);
        md_start = (state_q == S_IDLE) && (state_d == S_BUSY) && !bus.halt;
    end

    // Operand sign handling at start: signed ops run on magnitudes, sign restored at the end
    always_comb begin
        a_sgn = ((idex_q.md_op == 3'd1) || (idex_q.md_op == 3'd2) ||
                 (idex_q.md_op == 3'd4) || (idex_q.md_op == 3'd6)) && rs1_fwd[W-1];
        b_sgn = ((idex_q.md_op == 3'd1) || (idex_q.md_op == 3'd4) ||
                 (idex_q.md_op == 3'd6)) && rs2_fwd[W-1];
        a_mag = a_sgn ? -rs1_fwd : rs1_fwd;
        b_mag = b_sgn ? -rs2_fwd : rs2_fwd;
        // remainder's top bit going out means the shifted value already exceeds any divisor
        rem_shl = {rem_q[W-2:0], quo_q[W-1]};
        rem_ge  = rem_q[W-1] || (rem_shl >= dvsr_q);
    end

    // Mul/div datapath: one shift-add or one restoring step per busy cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvsr_q   <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            dz_q     <= 1'b0;
        end else if (md_start) begin
            cnt_q    <= SW'(W - 1);
            acc_q    <= '0;
            mcand_q  <= {{W{1'b0}}, a_mag};
            mplier_q <= b_mag;
            quo_q    <= a_mag;
            rem_q    <= '0;
            dvsr_q   <= b_mag;
            a_neg_q  <= a_sgn;
            b_neg_q  <= b_sgn;
            dz_q     <= (rs2_fwd == '0);
        end else if (!bus.halt && !bus.flush && (state_q == S_BUSY)) begin
            if (cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (idex_q.md_op[2]) begin
                rem_q <= rem_ge ? (rem_shl - dvsr_q) : rem_shl;
                quo_q <= {quo_q[W-2:0], rem_ge};
            end else begin
                if (mplier_q[0]) begin
                    acc_q <= acc_q + mcand_q;
                end
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
            end
        end
    end

    // Mul/div result with sign fixup; divide by zero forces an all-ones quotient
    always_comb begin
        prod_s = (a_neg_q ^ b_neg_q) ? -acc_q : acc_q;
        quo_s  = dz_q ? '1 : ((a_neg_q ^ b_neg_q) ? -quo_q : quo_q);
        rem_s  = a_neg_q ? -rem_q : rem_q;
        case (idex_q.md_op)
            3'd0:          md_res = prod_s[W-1:0];
            3'd1, 3'd2,
            3'd3:          md_res = prod_s[2*W-1:W];
            3'd4, 3'd5:    md_res = quo_s;
            default:       md_res = rem_s;
        endcase
    end

    // Stage outputs toward MEM, control bubbled while stalled
    always_comb begin
        if (idex_q.md_en) begin
            bus.rslt_out = md_res;
        end else if (idex_q.jmp) begin
            bus.rslt_out = pc_w + W'(4);
        end else if (idex_q.bch) begin
            bus.rslt_out = {{(W-1){1'b0}}, bch_take};
        end else begin
            bus.rslt_out = alu_res;
        end
        bus.tgt_addr_out = idex_q.jalr ? M'(jalr_sum & JALR_MASK) : M'(pc_w + idex_q.imm);
        bus.rs2_val_out  = rs2_fwd;
        bus.imm_ext_out  = idex_q.imm;
        bus.jmp_ctl_out  = idex_q.jmp    && !stall;
        bus.bch_ctl_out  = idex_q.bch    && !stall;
        bus.mem_ctl_out  = idex_q.mem    && !stall;
        bus.rd_wen_out   = idex_q.rd_wen && !stall;
        bus.wb_ctl_out   = idex_q.wb_ctl;
        bus.byt_typ_out  = idex_q.byt_typ;
        bus.rd_addr_out  = idex_q.rd_addr;
        bus.stall        = stall;
    end
endmodule
